// File: rtl/mul_add_16bit_seq_if.sv
// mul_add_16bit_seq_if: operand/result handshake bundle for mul_add_16bit_seq.
//   in_valid/in_ready   : operand handshake (q, b, r)
//   out_valid/out_ready : result handshake (result)
//   ovf16, rem_err      : range flags, present only with MUL_ADD_RANGE_CHECK_EN
// Modports: slave = the multiply-accumulate block, master = its driver.
interface mul_add_16bit_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   r;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
`ifdef MUL_ADD_RANGE_CHECK_EN
  logic               ovf16;
  logic               rem_err;
`endif

  modport slave (
    input  in_valid, q, b, r, out_ready,
`ifdef MUL_ADD_RANGE_CHECK_EN
    output ovf16, rem_err,
`endif
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, q, b, r, out_ready,
`ifdef MUL_ADD_RANGE_CHECK_EN
    input  ovf16, rem_err,
`endif
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/mul_add_16bit_seq.sv
// mul_add_16bit_seq: sequential shift-add multiply-accumulate, result = q*b + r.
// Rebuilds a dividend from a divider's quotient/divisor/remainder; one bit of q per cycle.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mul_add_16bit_seq_if.slave (in_valid/in_ready, q, b, r,
//            out_valid/out_ready, result[2*WIDTH-1:0])
// Macro MUL_ADD_RANGE_CHECK_EN adds bus.ovf16 (result does not fit WIDTH bits) and
// bus.rem_err (b != 0 and r >= b on the captured operands), both updated with result.
// Timing: accept edge, WIDTH RUN cycles, then DONE holds result until out_ready.
module mul_add_16bit_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  mul_add_16bit_seq_if.slave    bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]     q_sh_q, q_sh_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [2*WIDTH-1:0]   sum;

`ifdef MUL_ADD_RANGE_CHECK_EN
  logic rem_bad_q, rem_bad_d;  // remainder legality, captured at accept
  logic ovf16_q, ovf16_d;
  logic rem_err_q, rem_err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      b_sh_q    <= '0;
      q_sh_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
`ifdef MUL_ADD_RANGE_CHECK_EN
      rem_bad_q <= 1'b0;
      ovf16_q   <= 1'b0;
      rem_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      b_sh_q    <= b_sh_d;
      q_sh_q    <= q_sh_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
`ifdef MUL_ADD_RANGE_CHECK_EN
      rem_bad_q <= rem_bad_d;
      ovf16_q   <= ovf16_d;
      rem_err_q <= rem_err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    b_sh_d    = b_sh_q;
    q_sh_d    = q_sh_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    // Partial sum for this RUN step; wraps at 2*WIDTH bits.
    sum       = q_sh_q[0] ? (acc_q + b_sh_q) : acc_q;
`ifdef MUL_ADD_RANGE_CHECK_EN
    rem_bad_d = rem_bad_q;
    ovf16_d   = ovf16_q;
    rem_err_d = rem_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          acc_d   = {{WIDTH{1'b0}}, bus.r};
          b_sh_d  = {{WIDTH{1'b0}}, bus.b};
          q_sh_d  = bus.q;
          cnt_d   = '0;
          state_d = StRun;
`ifdef MUL_ADD_RANGE_CHECK_EN
          rem_bad_d = (bus.b != '0) && (bus.r >= bus.b);
`endif
        end
      end
      StRun: begin
        // Always WIDTH steps, even when q is zero, to keep latency fixed.
        acc_d  = sum;
        b_sh_d = b_sh_q << 1;
        q_sh_d = q_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          result_d = sum;
          state_d  = StDone;
`ifdef MUL_ADD_RANGE_CHECK_EN
          ovf16_d   = |sum[2*WIDTH-1:WIDTH];
          rem_err_d = rem_bad_q;
`endif
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
`ifdef MUL_ADD_RANGE_CHECK_EN
  assign bus.ovf16     = ovf16_q;
  assign bus.rem_err   = rem_err_q;
`endif

endmodule

// File: tb/tb_mul_add_16bit_seq.sv
// tb_mul_add_16bit_seq: directed and randomized bench for mul_add_16bit_seq.
// Expected values come from plain arithmetic (q*b + r) and a divide/modulo model of
// the upstream divider; the random sweep rebuilds the original dividend.
module tb_mul_add_16bit_seq;
  logic clk;
  logic rst_n;

  mul_add_16bit_seq_if #(.WIDTH(16)) bus ();

  mul_add_16bit_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mac_ref(input logic [15:0] qv, input logic [15:0] bv,
                                          input logic [15:0] rv);
    int unsigned p;
    p = int'(qv) * int'(bv) + int'(rv);
    return p;
  endfunction

  // Full transaction: present operands, count edges to out_valid, check result and flags,
  // optionally stall out_ready for `hold` cycles, then complete the handshake.
  task automatic op(input string tag, input logic [15:0] qv, input logic [15:0] bv,
                    input logic [15:0] rv, input logic [31:0] exp, input bit exp_ovf,
                    input bit exp_rem, input int hold);
    int n;
    @(negedge clk);
    bus.q = qv; bus.b = bv; bus.r = rv;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 60) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, 32'(n), 32'd17);
    check({tag, " result"}, bus.result, exp);
`ifdef MUL_ADD_RANGE_CHECK_EN
    check({tag, " ovf16"}, {31'b0, bus.ovf16}, {31'b0, exp_ovf});
    check({tag, " rem_err"}, {31'b0, bus.rem_err}, {31'b0, exp_rem});
`else
    if (exp_ovf && exp_rem) n = 0;  // flags only observable with the range-check build
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, {31'b0, bus.out_valid}, 32'd1);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " valid drop"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, " result kept"}, bus.result, exp);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] a, qv, bv, rv;
    int          n, highs;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.q = '0; bus.b = '0; bus.r = '0;
    #12;
    check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset result", bus.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Abort an operation with reset during RUN cycle 7.
    @(negedge clk);
    bus.q = 16'h1234; bus.b = 16'h0005; bus.r = 16'h0003; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    check("accept in_ready low", {31'b0, bus.in_ready}, 32'd0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("abort out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("abort result", bus.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    highs = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid) highs++;
    end
    check("abort no valid", 32'(highs), 32'd0);
    check("abort result hold", bus.result, 32'd0);

    // Directed cases.
    op("basic", 16'h1234, 16'h0005, 16'h0003, 32'h0000_5B07, 1'b0, 1'b0, 0);
    check("basic model", mac_ref(16'h1234, 16'h0005, 16'h0003), 32'h0000_5B07);
    op("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 1'b1, 1'b1, 2);
    op("b zero", 16'hFFFF, 16'h0000, 16'h00AB, 32'h0000_00AB, 1'b0, 1'b0, 0);
    op("q zero", 16'h0000, 16'h1234, 16'h0011, 32'h0000_0011, 1'b0, 1'b0, 1);

    // Backpressure: hold out_ready low in DONE while new operands wait on in_valid.
    @(negedge clk);
    bus.q = 16'h0100; bus.b = 16'h0200; bus.r = 16'h0055; bus.in_valid = 1'b1;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 60) begin @(posedge clk); #1; n++; end
    check("bp latency", 32'(n), 32'd17);
    @(negedge clk);
    bus.q = 16'h0007; bus.b = 16'h0009; bus.r = 16'h0002; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp result stable", bus.result, 32'h0002_0055);
      check("bp in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("bp valid", {31'b0, bus.out_valid}, 32'd1);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp valid drop", {31'b0, bus.out_valid}, 32'd0);
    check("bp idle ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp pending accept", {31'b0, bus.in_ready}, 32'd0);
    n = 1;
    while (!bus.out_valid && n < 60) begin @(posedge clk); #1; n++; end
    check("bp2 latency", 32'(n), 32'd17);
    check("bp2 result", bus.result, 32'h0000_0041);
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp2 valid drop", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    // Random sweep through a divider model; the rebuilt value must equal the dividend.
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom);
      bv = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
      if (bv == 16'h0000) begin
        qv = 16'hFFFF;
        rv = a;
      end else begin
        qv = a / bv;
        rv = a % bv;
      end
      op("sweep", qv, bv, rv, {16'h0000, a}, 1'b0, 1'b0, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
